// File: rtl/vdp_vram_arbiter.sv
// rtl/vdp_vram_arbiter.sv - single-port VRAM slot scheduler for vdp99
// Display fetch always wins the slot; the CPU is served in free (optionally blanking-only) slots.
module vdp_vram_arbiter #(
  parameter int AW           = 14,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 64,
  parameter int GC_BITS      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vid_active0,
  input  logic               end_of_frame,
  input  logic               cpu_blank_only,
  input  logic               disp_req,
  input  logic [AW-1:0]      disp_addr,
  output logic               disp_valid,
  output logic [DW-1:0]      disp_data,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  output logic               cpu_ack,
  output logic [DW-1:0]      cpu_rdata,
  output logic [AW-1:0]      vram_addr,
  output logic               vram_we,
  output logic [DW-1:0]      vram_wdata,
  input  logic [DW-1:0]      vram_rdata,
  output logic               cpu_starved,
  output logic [GC_BITS-1:0] cpu_grants
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD1, RD2} cpu_state_t;

  cpu_state_t         state;
  logic [1:0]         disp_pipe;
  logic [SW-1:0]      starve_cnt;
  logic [SW-1:0]      starve_next;
  logic [GC_BITS-1:0] grant_cnt;
  logic [GC_BITS-1:0] grant_next;
  logic               cpu_grant;

  // A request still held during the ack cycle is the old access, not a new one.
  always_comb begin
    cpu_grant = !disp_req && cpu_req && (state == IDLE) && !cpu_ack &&
                !(cpu_blank_only && vid_active0);
    grant_next = grant_cnt;
    if (cpu_grant && (grant_cnt != {GC_BITS{1'b1}}))
      grant_next = grant_cnt + GC_BITS'(1);
    starve_next = starve_cnt;
    if (cpu_grant || !cpu_req)
      starve_next = '0;
    else if ((state == IDLE) && (starve_cnt != STARVE_MAX))
      starve_next = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      disp_pipe   <= '0;
      disp_valid  <= 1'b0;
      disp_data   <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      vram_addr   <= '0;
      vram_we     <= 1'b0;
      vram_wdata  <= '0;
      starve_cnt  <= '0;
      cpu_starved <= 1'b0;
      grant_cnt   <= '0;
      cpu_grants  <= '0;
    end else begin
      vram_we <= 1'b0;
      cpu_ack <= 1'b0;

      // Two stages cover the registered address plus the VRAM's own read register.
      disp_pipe  <= {disp_pipe[0], disp_req};
      disp_valid <= disp_pipe[1];
      if (disp_pipe[1])
        disp_data <= vram_rdata;

      if (disp_req) begin
        vram_addr <= disp_addr;
      end else if (cpu_grant) begin
        vram_addr <= cpu_addr;
        if (cpu_we) begin
          vram_we    <= 1'b1;
          vram_wdata <= cpu_wdata;
          cpu_ack    <= 1'b1;
        end else begin
          state <= RD1;
        end
      end

      case (state)
        RD1: state <= RD2;
        RD2: begin
          state     <= IDLE;
          cpu_ack   <= 1'b1;
          cpu_rdata <= vram_rdata;
        end
        default: ;
      endcase

      starve_cnt  <= starve_next;
      cpu_starved <= (starve_next == STARVE_MAX);

      if (end_of_frame) begin
        cpu_grants <= grant_next;
        grant_cnt  <= '0;
      end else begin
        grant_cnt <= grant_next;
      end
    end
  end

endmodule
